// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature-sensor target.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrPtr,
    StWrData,
    StWrAck,
    StRdByte,
    StRdAck
  } i2c_state_e;

  localparam logic [1:0] REG_TEMP  = 2'd0;
  localparam logic [1:0] REG_CFG   = 2'd1;
  localparam logic [1:0] REG_THIGH = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam logic [7:0] TEMP_RST  = 8'h00;
  localparam logic [7:0] CFG_RST   = 8'h01;
  localparam logic [7:0] THIGH_RST = 8'h50;

  function automatic logic [7:0] reg_select(input logic [1:0] idx, input logic [7:0] temp,
                                            input logic [7:0] cfg, input logic [7:0] thigh,
                                            input logic [7:0] id);
    unique case (idx)
      REG_TEMP:  reg_select = temp;
      REG_CFG:   reg_select = cfg;
      REG_THIGH: reg_select = thigh;
      REG_ID:    reg_select = id;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for scl/sda plus edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_now, sda_now, scl_stable_high;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_now  = scl_sync_q[1];
  assign sda_now  = sda_sync_q[1];
  assign sda_sync = sda_now;

  assign scl_rise = scl_now & ~scl_prev_q;
  assign scl_fall = ~scl_now & scl_prev_q;

  // scl must be high in both samples, so a simultaneous scl/sda edge is just data
  assign scl_stable_high = scl_now & scl_prev_q;
  assign start_det       = scl_stable_high & sda_prev_q & ~sda_now;
  assign stop_det        = scl_stable_high & ~sda_prev_q & sda_now;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target exposing TEMP/CONFIG/THIGH/ID registers with an over-temperature alert.
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter logic [7:0] ID_VALUE = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       alert,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda_sync)
  );

  i2c_state_e state_q;
  logic [7:0] shift_q, temp_q, cfg_q, thigh_q;
  logic [1:0] ptr_q;
  logic [3:0] bit_cnt_q;
  logic       phase_q, sda_oe_q, alert_q;

  logic [7:0] byte_in, rd_cur, rd_next;
  logic [1:0] ptr_inc;

  assign byte_in = {shift_q[6:0], sda_sync};
  assign ptr_inc = ptr_q + 2'd1;
  assign rd_cur  = reg_select(ptr_q, temp_q, cfg_q, thigh_q, ID_VALUE);
  assign rd_next = reg_select(ptr_inc, temp_q, cfg_q, thigh_q, ID_VALUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= REG_TEMP;
      phase_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      cfg_q     <= CFG_RST;
      thigh_q   <= THIGH_RST;
    end else if (start_det) begin
      state_q   <= StAddr;
      bit_cnt_q <= 4'd0;
      phase_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (stop_det) begin
      state_q  <= StIdle;
      phase_q  <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StWrPtr, StWrData: begin
          if (scl_rise) begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= 4'd0;
              if (state_q == StAddr) begin
                state_q <= (byte_in[7:1] == DEV_ADDR) ? StAddrAck : StIdle;
              end else if (state_q == StWrPtr) begin
                ptr_q   <= byte_in[1:0];
                state_q <= StWrAck;
              end else begin
                // TEMP and ID are read-only: the byte is dropped but still ACKed
                if (ptr_q == REG_CFG) cfg_q <= byte_in;
                if (ptr_q == REG_THIGH) thigh_q <= byte_in;
                ptr_q   <= ptr_inc;
                state_q <= StWrAck;
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          // phase 0: assert ACK on the fall ending bit 8; phase 1: release on the 9th fall
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b1;
              phase_q  <= 1'b1;
            end else begin
              phase_q   <= 1'b0;
              bit_cnt_q <= 4'd0;
              if (state_q == StAddrAck && shift_q[0]) begin
                shift_q  <= rd_cur;
                sda_oe_q <= ~rd_cur[7];
                state_q  <= StRdByte;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == StAddrAck) ? StWrPtr : StWrData;
              end
            end
          end
        end
        StRdByte: begin
          if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            shift_q   <= {shift_q[6:0], 1'b0};
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              phase_q   <= 1'b0;
              state_q   <= StRdAck;
            end else begin
              sda_oe_q <= ~shift_q[7];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_sync) state_q <= StIdle;
            else phase_q <= 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_q  <= 1'b0;
            ptr_q    <= ptr_inc;
            shift_q  <= rd_next;
            sda_oe_q <= ~rd_next[7];
            state_q  <= StRdByte;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_q <= TEMP_RST;
    end else if (temp_valid) begin
      temp_q <= temp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alert_q <= 1'b0;
    end else begin
      alert_q <= cfg_q[0] && (temp_q > thigh_q);
    end
  end

  assign sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign alert = alert_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_temp_target.sv
// Randomized bench for i2c_temp_target: bus-level master, register model, named scoreboard.
module tb_i2c_temp_target;

  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst, scl, sda_m_oe, temp_valid;
  logic [7:0] temp_in;
  logic       alert, busy;
  wire        sda;

  pullup (sda);
  assign sda = sda_m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_temp_target #(
    .DEV_ADDR (7'h48),
    .ID_VALUE (8'h5A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .alert      (alert),
    .busy       (busy)
  );

  // Reference model of the register map
  logic [7:0] m_temp, m_cfg, m_thigh;
  logic [1:0] m_ptr;

  task automatic model_reset();
    m_temp = 8'h00; m_cfg = 8'h01; m_thigh = 8'h50; m_ptr = 2'd0;
  endtask

  function automatic logic [7:0] m_reg(input logic [1:0] i);
    if (i == 2'd0) return m_temp;
    if (i == 2'd1) return m_cfg;
    if (i == 2'd2) return m_thigh;
    return 8'h5A;
  endfunction

  function automatic logic m_alert();
    return m_cfg[0] && (m_temp > m_thigh);
  endfunction

  // Scoreboard: expectations pushed at stimulus time, matched by name when observed
  string      exp_name_q[$];
  logic [7:0] exp_val_q[$];
  string      obs_name_q[$];
  logic [7:0] obs_val_q[$];
  event       obs_ev;
  int         checks = 0;
  int         errors = 0;

  task automatic expect_val(input string n, input logic [7:0] v);
    exp_name_q.push_back(n);
    exp_val_q.push_back(v);
  endtask

  task automatic observe(input string n, input logic [7:0] v);
    obs_name_q.push_back(n);
    obs_val_q.push_back(v);
    ->obs_ev;
  endtask

  task automatic chk(input string n, input logic [7:0] e, input logic [7:0] a);
    expect_val(n, e);
    observe(n, a);
  endtask

  initial begin : monitor
    string      on;
    logic [7:0] ov;
    int         idx;
    forever begin
      @(obs_ev);
      while (obs_name_q.size() > 0) begin
        on  = obs_name_q.pop_front();
        ov  = obs_val_q.pop_front();
        idx = -1;
        foreach (exp_name_q[i]) if (idx < 0 && exp_name_q[i] == on) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL %s: got %02h, no expected value queued", on, ov);
        end else begin
          if (exp_val_q[idx] !== ov) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", on, ov, exp_val_q[idx], $time);
          end
          exp_name_q.delete(idx);
          exp_val_q.delete(idx);
        end
      end
    end
  end

  // Counts clocks where sda is low without the master pulling it
  int drive_cnt = 0;
  always @(negedge clk) if (!sda_m_oe && sda !== 1'b1) drive_cnt <= drive_cnt + 1;

  // Bus master primitives
  task automatic bus_start();
    sda_m_oe = 1'b0; #Q; scl = 1'b1; #Q; sda_m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m_oe = 1'b1; #Q; scl = 1'b1; #Q; sda_m_oe = 1'b0; #Q;
  endtask

  task automatic wr_bit(input logic b);
    sda_m_oe = ~b; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0; #Q;
  endtask

  task automatic rd_bit(output logic b);
    sda_m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(~ack);
  endtask

  task automatic pulse_temp(input logic [7:0] v);
    logic pre;
    @(negedge clk);
    temp_in = v; temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    pre = m_alert();
    m_temp = v;
    chk("alert_lag", 8'(pre), 8'(alert));
    @(negedge clk);
    chk("alert", 8'(m_alert()), 8'(alert));
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [7:0] d0, input bit stop_en);
    logic       ack, hit;
    logic [7:0] d;
    hit = (a == 7'h48);
    bus_start();
    expect_val("ack", 8'(hit));
    wr_byte({a, 1'b0}, ack);
    observe("ack", 8'(ack));
    if (hit) begin
      expect_val("ack", 8'h01);
      wr_byte(p, ack);
      observe("ack", 8'(ack));
      m_ptr = p[1:0];
      for (int i = 0; i < n; i++) begin
        d = (i == 0) ? d0 : 8'($urandom);
        expect_val("ack", 8'h01);
        wr_byte(d, ack);
        observe("ack", 8'(ack));
        if (m_ptr == 2'd1) m_cfg = d;
        if (m_ptr == 2'd2) m_thigh = d;
        m_ptr = m_ptr + 2'd1;
      end
    end else begin
      chk("miss_busy", 8'h00, 8'(busy));
      expect_val("ack", 8'h00);
      wr_byte(p, ack);
      observe("ack", 8'(ack));
    end
    if (stop_en) begin
      bus_stop();
      @(negedge clk);
      chk("busy", 8'h00, 8'(busy));
      chk("alert", 8'(m_alert()), 8'(alert));
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic       ack, hit, last;
    logic [7:0] d;
    hit = (a == 7'h48);
    bus_start();
    expect_val("ack", 8'(hit));
    wr_byte({a, 1'b1}, ack);
    observe("ack", 8'(ack));
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        last = (i == n - 1);
        expect_val("rd", m_reg(m_ptr));
        rd_byte(~last, d);
        observe("rd", d);
        if (!last) m_ptr = m_ptr + 2'd1;
      end
      chk("sda_rel", 8'h01, 8'(sda));
    end
    bus_stop();
    @(negedge clk);
    chk("busy", 8'h00, 8'(busy));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: run still going, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] abyte;
    int         cnt0;
    rst = 1'b1; scl = 1'b1; sda_m_oe = 1'b0; temp_valid = 1'b0; temp_in = 8'h00;
    model_reset();
    #23 rst = 1'b0;
    #20;
    @(negedge clk);
    chk("rst_busy", 8'h00, 8'(busy));
    chk("rst_alert", 8'h00, 8'(alert));
    chk("rst_sda", 8'h01, 8'(sda));

    // THIGH = 0x30 then TEMP 0x40 raises alert one cycle after the load
    do_write(7'h48, 8'h02, 1, 8'h30, 1'b1);
    pulse_temp(8'h40);

    // Pointer 0, repeated START, read three bytes
    do_write(7'h48, 8'h00, 0, 8'h00, 1'b0);
    do_read(7'h48, 3);

    // Address 0xA0 is not ours
    cnt0 = drive_cnt;
    do_write(7'h50, 8'h01, 0, 8'h00, 1'b1);
    chk("no_drive", 8'h00, 8'(drive_cnt != cnt0));

    // Pointer wrap 3 -> 0
    do_write(7'h48, 8'h03, 0, 8'h00, 1'b0);
    do_read(7'h48, 2);

    // TEMP update mid-byte must not tear the byte in flight
    do_write(7'h48, 8'h00, 0, 8'h00, 1'b1);
    fork
      do_read(7'h48, 1);
      begin
        #(4 * Q + 9 * 4 * Q + 3 * 4 * Q);
        pulse_temp(8'h7F);
      end
    join
    do_read(7'h48, 1);

    // Reset while the target holds the address ACK
    abyte = 8'h90;
    bus_start();
    for (int i = 7; i >= 0; i--) wr_bit(abyte[i]);
    sda_m_oe = 1'b0;
    #20;
    chk("ack_hold", 8'h00, 8'(sda));
    rst = 1'b1;
    #1;
    chk("rst_rel", 8'h01, 8'(sda));
    chk("rst_busy2", 8'h00, 8'(busy));
    #9 scl = 1'b1;
    #40 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_alert2", 8'h00, 8'(alert));
    do_write(7'h48, 8'h02, 1, 8'($urandom), 1'b1);
    do_read(7'h48, 3);

    for (int it = 0; it < 20; it++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'h48;
      case ($urandom_range(0, 2))
        0:       do_write(a, 8'($urandom), $urandom_range(0, 3), 8'($urandom), 1'b1);
        1:       do_read(a, $urandom_range(1, 4));
        default: pulse_temp(8'($urandom));
      endcase
    end

    #200;
    while (exp_name_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got nothing, expected %02h", exp_name_q[0], exp_val_q[0]);
      void'(exp_name_q.pop_front());
      void'(exp_val_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
